// File: rtl/aim_axil_mailbox_if.sv
// AXI-Lite slave channel bundle used by the host-facing side of the AI-core mailbox.
interface aim_axil_mailbox_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rvalid;
    logic                  s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/aim_axil_mailbox.sv
// AXI-Lite mailbox: host loads command slots and rings a doorbell to launch one to the
// AI core; core results are queued in a FIFO that the host drains by reading RESULT.
module aim_axil_mailbox #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned RES_DEPTH  = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    aim_axil_mailbox_if.slave s,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [3:0]        cmd_ch,
    output logic [31:0]       cmd_instr,
    output logic [31:0]       cmd_data,
    input  logic              res_valid,
    input  logic [31:0]       res_data,
    output logic              irq
);
    localparam int unsigned PW     = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [8:0]  DEPTH  = 9'(RES_DEPTH);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [2:0] {
        A_CTRL, A_STATUS, A_RESULT, A_DOORBELL, A_INSTR, A_DATA, A_NONE
    } area_e;

    function automatic area_e decode(input logic [ADDR_WIDTH-1:0] addr, output int unsigned ch);
        int unsigned w;
        w  = 32'(addr) >> 2;
        ch = 0;
        case (w)
            0:       return A_CTRL;
            1:       return A_STATUS;
            2:       return A_RESULT;
            3:       return A_DOORBELL;
            default: begin
                if (w < 4 + 2 * NUM_CH) begin
                    ch = (w - 4) >> 1;
                    return w[0] ? A_DATA : A_INSTR;
                end
                return A_NONE;
            end
        endcase
    endfunction

    state_e                state_q, state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  enable_q, enable_d, irq_en_q, irq_en_d;
    logic                  overflow_q, overflow_d, irq_q, irq_d;
    logic [3:0]            cmd_ch_q, cmd_ch_d;
    logic [31:0]           cmd_instr_q, cmd_instr_d, cmd_data_q, cmd_data_d;
    logic [31:0]           instr_q [NUM_CH];
    logic [31:0]           instr_d [NUM_CH];
    logic [31:0]           data_q  [NUM_CH];
    logic [31:0]           data_d  [NUM_CH];
    logic [31:0]           fifo_q  [RES_DEPTH];
    logic [31:0]           fifo_d  [RES_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [8:0]            count_q, count_d;

    logic                  aw_acc, w_acc, ar_acc, aw_have, w_have;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  push, pop, flush, ov_clr, ov_set, full;
    area_e                 w_area, r_area;
    int unsigned           w_ch, r_ch;

    assign s.s_awready = !aw_held_q && !bvalid_q;
    assign s.s_wready  = !w_held_q && !bvalid_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = !rvalid_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;
    assign cmd_valid   = (state_q == BUSY);
    assign cmd_ch      = cmd_ch_q;
    assign cmd_instr   = cmd_instr_q;
    assign cmd_data    = cmd_data_q;
    assign irq         = irq_q;
    assign full        = (count_q == DEPTH);

    always_comb begin
        state_d     = state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        cmd_ch_d    = cmd_ch_q;
        cmd_instr_d = cmd_instr_q;
        cmd_data_d  = cmd_data_q;
        instr_d     = instr_q;
        data_d      = data_q;
        fifo_d      = fifo_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        ov_clr      = 1'b0;
        ov_set      = 1'b0;
        w_ch        = 0;
        r_ch        = 0;
        w_area      = A_NONE;
        r_area      = A_NONE;

        if (bvalid_q && s.s_bready) bvalid_d = 1'b0;
        if (rvalid_q && s.s_rready) rvalid_d = 1'b0;
        if (state_q == BUSY && cmd_ready) state_d = IDLE;

        // A channel accepted this cycle counts as held so AW+W together commit at once.
        aw_acc  = s.s_awvalid && s.s_awready;
        w_acc   = s.s_wvalid && s.s_wready;
        aw_have = aw_held_q || aw_acc;
        w_have  = w_held_q || w_acc;
        waddr   = aw_held_q ? awaddr_q : s.s_awaddr;
        wdata   = w_held_q ? wdata_q : s.s_wdata;
        wstrb   = w_held_q ? wstrb_q : s.s_wstrb;
        if (aw_acc) begin
            aw_held_d = 1'b1;
            awaddr_d  = s.s_awaddr;
        end
        if (w_acc) begin
            w_held_d = 1'b1;
            wdata_d  = s.s_wdata;
            wstrb_d  = s.s_wstrb;
        end

        if (aw_have && w_have) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = OKAY;
            w_area    = decode(waddr, w_ch);
            case (w_area)
                A_CTRL: if (wstrb[0]) begin
                    enable_d = wdata[0];
                    flush    = wdata[1];
                    irq_en_d = wdata[2];
                end
                A_STATUS: ov_clr = wstrb[0] && wdata[2];
                A_DOORBELL: if (wstrb[0]) begin
                    if (state_q == BUSY || !enable_q || 32'(wdata[3:0]) >= NUM_CH) begin
                        bresp_d = SLVERR;
                    end else begin
                        state_d  = BUSY;
                        cmd_ch_d = wdata[3:0];
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (i == 32'(wdata[3:0])) begin
                                cmd_instr_d = instr_q[i];
                                cmd_data_d  = data_q[i];
                            end
                        end
                    end
                end
                A_INSTR, A_DATA: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (i == w_ch && wstrb[b]) begin
                                if (w_area == A_INSTR) instr_d[i][8*b +: 8] = wdata[8*b +: 8];
                                else                   data_d[i][8*b +: 8]  = wdata[8*b +: 8];
                            end
                        end
                    end
                end
                A_NONE:  bresp_d = SLVERR;
                default: ;
            endcase
        end

        ar_acc = s.s_arvalid && !rvalid_q;
        if (ar_acc) begin
            rvalid_d = 1'b1;
            rresp_d  = OKAY;
            rdata_d  = '0;
            r_area   = decode(s.s_araddr, r_ch);
            case (r_area)
                A_CTRL:   rdata_d = {29'h0, irq_en_q, 1'b0, enable_q};
                A_STATUS: rdata_d = {16'h0, count_q[7:0], 4'h0, state_q == BUSY,
                                     overflow_q, full, count_q != 9'd0};
                A_RESULT: if (count_q != 9'd0) begin
                    rdata_d = fifo_q[rptr_q];
                    pop     = 1'b1;
                end
                A_INSTR, A_DATA: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (i == r_ch) rdata_d = (r_area == A_INSTR) ? instr_q[i] : data_q[i];
                    end
                end
                A_NONE:  rresp_d = SLVERR;
                default: ;
            endcase
        end

        // Flush wins over any same-cycle push; a pop that cycle already sampled its data.
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (res_valid) begin
                if (!full || pop) begin
                    fifo_d[wptr_q] = res_data;
                    wptr_d         = wptr_q + 1'b1;
                    push           = 1'b1;
                end else begin
                    ov_set = 1'b1;
                end
            end
            if (pop) rptr_d = rptr_q + 1'b1;
            count_d = count_q + 9'(push) - 9'(pop);
        end
        overflow_d = ov_set || (overflow_q && !ov_clr);
        irq_d      = irq_en_q && (count_q != 9'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
            rvalid_q    <= 1'b0;
            rresp_q     <= OKAY;
            rdata_q     <= '0;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            overflow_q  <= 1'b0;
            irq_q       <= 1'b0;
            cmd_ch_q    <= '0;
            cmd_instr_q <= '0;
            cmd_data_q  <= '0;
            instr_q     <= '{default: '0};
            data_q      <= '{default: '0};
            fifo_q      <= '{default: '0};
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            overflow_q  <= overflow_d;
            irq_q       <= irq_d;
            cmd_ch_q    <= cmd_ch_d;
            cmd_instr_q <= cmd_instr_d;
            cmd_data_q  <= cmd_data_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            fifo_q      <= fifo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_aim_axil_mailbox.sv
// Directed/randomized bench for aim_axil_mailbox against a queue-based register model.
module tb_aim_axil_mailbox;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned RES_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_ch;
    logic [31:0] cmd_instr, cmd_data;
    logic        res_valid;
    logic [31:0] res_data;
    logic        irq;

    aim_axil_mailbox_if #(.ADDR_WIDTH(8)) bus ();

    aim_axil_mailbox #(.NUM_CH(NUM_CH), .RES_DEPTH(RES_DEPTH), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .s(bus),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_instr(cmd_instr), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_data(res_data), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] m_instr [NUM_CH];
    logic [31:0] m_data  [NUM_CH];
    bit          m_en, m_irqen, m_busy, m_ov;
    logic [3:0]  m_ch;
    logic [31:0] m_cmd_instr, m_cmd_data;
    logic [31:0] m_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_instr[i] = '0;
            m_data[i]  = '0;
        end
        m_en = 0; m_irqen = 0; m_busy = 0; m_ov = 0; m_ch = '0;
        m_q.delete();
    endfunction

    function automatic logic [31:0] m_status();
        logic [7:0] c;
        c = 8'(m_q.size());
        return {16'h0, c, 4'h0, m_busy, m_ov, m_q.size() == RES_DEPTH, m_q.size() != 0};
    endfunction

    function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st);
        int unsigned w, ch;
        w = 32'(a) / 4;
        if (w == 0) begin
            if (st[0]) begin
                m_en = d[0]; m_irqen = d[2];
                if (d[1]) m_q.delete();
            end
            return 2'b00;
        end
        if (w == 1) begin
            if (st[0] && d[2]) m_ov = 0;
            return 2'b00;
        end
        if (w == 2) return 2'b00;
        if (w == 3) begin
            if (!st[0]) return 2'b00;
            if (m_busy || !m_en || 32'(d[3:0]) >= NUM_CH) return 2'b10;
            m_busy = 1; m_ch = d[3:0];
            m_cmd_instr = m_instr[d[3:0]];
            m_cmd_data  = m_data[d[3:0]];
            return 2'b00;
        end
        if (w >= 4 + 2 * NUM_CH) return 2'b10;
        ch = (w - 4) / 2;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) begin
                if (w % 2 == 1) m_data[ch][8*b +: 8]  = d[8*b +: 8];
                else            m_instr[ch][8*b +: 8] = d[8*b +: 8];
            end
        end
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int unsigned w;
        w = 32'(a) / 4;
        d = '0;
        r = 2'b00;
        if (w == 0) d = {29'h0, m_irqen, 1'b0, m_en};
        else if (w == 1) d = m_status();
        else if (w == 2) begin
            if (m_q.size() != 0) d = m_q.pop_front();
        end
        else if (w == 3) d = '0;
        else if (w < 4 + 2 * NUM_CH) d = (w % 2 == 1) ? m_data[(w-4)/2] : m_instr[(w-4)/2];
        else r = 2'b10;
    endfunction

    function automatic void model_push(input logic [31:0] v);
        if (m_q.size() < RES_DEPTH) m_q.push_back(v);
        else m_ov = 1;
    endfunction

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int bcyc, output int fcyc);
        bit aw_done = 0, w_done = 0, b_done = 0, aw_f, w_f, b_f;
        int cyc = 0;
        bcyc = -1; fcyc = -1; resp = 2'b11;
        bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = st;
        while (!b_done && cyc < 100) begin
            bus.s_awvalid = !aw_done && cyc >= aw_dly;
            bus.s_wvalid  = !w_done && cyc >= w_dly;
            bus.s_bready  = cyc >= b_dly;
            aw_f = bus.s_awvalid && bus.s_awready;
            w_f  = bus.s_wvalid && bus.s_wready;
            b_f  = bus.s_bvalid && bus.s_bready;
            if (bus.s_bvalid && bcyc < 0) bcyc = cyc;
            if (b_f) begin resp = bus.s_bresp; fcyc = cyc; end
            @(posedge clk); #1;
            cyc++;
            aw_done |= aw_f; w_done |= w_f; b_done = b_f;
        end
        bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_bready = 0;
        if (!b_done) chk("write_timeout", 0, 1);
    endtask

    task automatic axi_read(input logic [7:0] a, input int r_dly, input bit push_en, input logic [31:0] push_val,
                            output logic [31:0] data, output logic [1:0] resp, output bit stable);
        bit ar_done = 0, r_done = 0, seen = 0, ar_f, r_f;
        logic [31:0] first = '0;
        logic [1:0]  first_r = '0;
        int cyc = 0;
        data = '0; resp = 2'b11; stable = 0;
        bus.s_araddr = a;
        while (!r_done && cyc < 100) begin
            bus.s_arvalid = !ar_done;
            bus.s_rready  = cyc >= r_dly;
            res_valid     = push_en && cyc == 0;
            res_data      = push_val;
            ar_f = bus.s_arvalid && bus.s_arready;
            r_f  = bus.s_rvalid && bus.s_rready;
            if (bus.s_rvalid && !seen) begin seen = 1; first = bus.s_rdata; first_r = bus.s_rresp; end
            if (r_f) begin
                data = bus.s_rdata; resp = bus.s_rresp;
                stable = (data === first) && (resp === first_r);
            end
            @(posedge clk); #1;
            cyc++;
            ar_done |= ar_f; r_done = r_f;
        end
        bus.s_arvalid = 0; bus.s_rready = 0; res_valid = 0;
        if (!r_done) chk("read_timeout", 0, 1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st, input string tag);
        logic [1:0] er, resp;
        int bc, fc;
        er = model_write(a, d, st);
        axi_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp, bc, fc);
        chk({tag, "_bresp"}, 32'(resp), 32'(er));
    endtask

    task automatic rd(input logic [7:0] a, input string tag, input bit push_en, input logic [31:0] push_val,
                      output logic [31:0] obs);
        logic [31:0] ed;
        logic [1:0]  er, resp;
        bit          stable;
        model_read(a, ed, er);
        if (push_en) model_push(push_val);
        axi_read(a, $urandom_range(0, 4), push_en, push_val, obs, resp, stable);
        chk({tag, "_rdata"}, obs, ed);
        chk({tag, "_rresp"}, 32'(resp), 32'(er));
        chk({tag, "_rhold"}, 32'(stable), 1);
    endtask

    task automatic push_res(input logic [31:0] v);
        res_valid = 1; res_data = v;
        @(posedge clk); #1;
        res_valid = 0;
        model_push(v);
    endtask

    initial begin
        logic [31:0] obs, prev_instr;
        logic [1:0]  resp;
        int          bc, fc;
        bit          ok;

        reset = 1; cmd_ready = 0; res_valid = 0; res_data = '0;
        bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 0;
        bus.s_bready = 0; bus.s_araddr = '0; bus.s_arvalid = 0; bus.s_rready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bvalid", 32'(bus.s_bvalid), 0);
        chk("rst_bresp", 32'(bus.s_bresp), 0);
        chk("rst_rvalid", 32'(bus.s_rvalid), 0);
        chk("rst_rresp", 32'(bus.s_rresp), 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd_instr", cmd_instr, 0);
        chk("rst_irq", 32'(irq), 0);
        reset = 0;
        @(posedge clk); #1;
        rd(8'h04, "rst_status", 0, 0, obs);
        rd(8'h00, "rst_ctrl", 0, 0, obs);
        rd(8'h10, "rst_instr0", 0, 0, obs);

        // W arrives three cycles after AW
        void'(model_write(8'h10, 32'hA5A5_0001, 4'hF));
        axi_write(8'h10, 32'hA5A5_0001, 4'hF, 0, 3, 0, resp, bc, fc);
        chk("aw_w_gap_bresp", 32'(resp), 0);
        chk("aw_w_gap_bcyc", bc, 4);
        rd(8'h10, "instr0", 0, 0, obs);
        chk("instr0_value", obs, 32'hA5A5_0001);

        void'(model_write(8'h14, 32'hFFFF_FFFF, 4'h3));
        axi_write(8'h14, 32'hFFFF_FFFF, 4'h3, 0, 0, 0, resp, bc, fc);
        chk("aw_w_same_bcyc", bc, 1);
        rd(8'h14, "data0", 0, 0, obs);
        chk("data0_strb", obs, 32'h0000_FFFF);

        void'(model_write(8'h18, 32'h1234_5678, 4'hF));
        axi_write(8'h18, 32'h1234_5678, 4'hF, 1, 0, 5, resp, bc, fc);
        chk("bstall_fire_cyc", fc, 5);
        chk("bstall_bresp", 32'(resp), 0);

        for (int i = 0; i < 12; i++)
            wr(8'(32'h10 + 4 * $urandom_range(0, 2 * NUM_CH - 1)), $urandom, 4'($urandom_range(0, 15)), "rnd_slot");
        for (int k = 0; k < 2 * NUM_CH; k++) rd(8'(32'h10 + 4 * k), "slot_rb", 0, 0, obs);

        // Command launch and backpressure
        wr(8'h00, 32'h1, 4'hF, "ctrl_en");
        wr(8'h0C, 32'h2, 4'h1, "db2");
        chk("db2_cmd_valid", 32'(cmd_valid), 1);
        chk("db2_cmd_ch", 32'(cmd_ch), 2);
        chk("db2_cmd_instr", cmd_instr, m_cmd_instr);
        chk("db2_cmd_data", cmd_data, m_cmd_data);
        ok = 1;
        prev_instr = cmd_instr;
        repeat (5) begin
            @(posedge clk); #1;
            if (cmd_valid !== 1'b1 || cmd_ch !== 4'd2 || cmd_instr !== m_cmd_instr || cmd_data !== m_cmd_data) ok = 0;
        end
        chk("cmd_stable", 32'(ok), 1);
        wr(8'h0C, 32'h1, 4'h1, "db_busy");
        chk("db_busy_cmd_ch", 32'(cmd_ch), 2);
        wr(8'h20, $urandom, 4'hF, "slot2_rewrite");
        chk("rewrite_cmd_instr", cmd_instr, prev_instr);
        rd(8'h04, "status_busy", 0, 0, obs);
        cmd_ready = 1;
        @(posedge clk); #1;
        cmd_ready = 0;
        m_busy = 0;
        chk("cmd_done", 32'(cmd_valid), 0);

        wr(8'h0C, 32'hF, 4'h1, "db_slot15");
        wr(8'h0C, 32'h1, 4'h2, "db_nostrb");
        chk("db_nostrb_idle", 32'(cmd_valid), 0);
        wr(8'h00, 32'h0, 4'h1, "ctrl_dis");
        wr(8'h0C, 32'h1, 4'h1, "db_disabled");
        wr(8'h00, 32'h5, 4'h1, "ctrl_en_irq");
        wr(8'h0C, 32'h3, 4'h1, "db3");
        chk("db3_cmd_instr", cmd_instr, m_cmd_instr);
        chk("db3_cmd_data", cmd_data, m_cmd_data);
        cmd_ready = 1;
        @(posedge clk); #1;
        cmd_ready = 0;
        m_busy = 0;

        // Overflowing the result FIFO
        for (int v = 1; v <= RES_DEPTH + 1; v++) push_res(32'(v));
        rd(8'h04, "status_full", 0, 0, obs);
        chk("status_full_value", obs, 32'h0000_0807);
        chk("irq_full", 32'(irq), 1);
        wr(8'h04, 32'h4, 4'h1, "w1c_ov");
        rd(8'h04, "status_w1c", 0, 0, obs);
        for (int v = 1; v <= RES_DEPTH; v++) begin
            rd(8'h08, "pop", 0, 0, obs);
            chk("pop_order", obs, 32'(v));
        end
        rd(8'h08, "pop_empty", 0, 0, obs);
        rd(8'h04, "status_empty", 0, 0, obs);
        chk("irq_empty", 32'(irq), 0);

        // Push and pop in the same cycle while full
        for (int v = 0; v < RES_DEPTH; v++) push_res($urandom);
        rd(8'h08, "pop_push_full", 1, $urandom, obs);
        rd(8'h04, "status_pp", 0, 0, obs);
        for (int v = 0; v < RES_DEPTH; v++) rd(8'h08, "pp_drain", 0, 0, obs);

        // Flush keeps the sticky overflow
        for (int v = 0; v < RES_DEPTH + 1; v++) push_res($urandom);
        wr(8'h00, 32'h7, 4'h1, "flush");
        rd(8'h04, "status_flush", 0, 0, obs);
        rd(8'h00, "ctrl_after_flush", 0, 0, obs);

        rd(8'hFC, "rd_unmapped", 0, 0, obs);
        wr(8'hFC, $urandom, 4'hF, "wr_unmapped");
        rd(8'h0C, "rd_doorbell", 0, 0, obs);

        // Asynchronous reset with a command pending and a write half-accepted
        wr(8'h0C, 32'h0, 4'h1, "db0");
        push_res($urandom);
        @(posedge clk); #1;
        bus.s_awaddr = 8'h10; bus.s_awvalid = 1;
        @(posedge clk); #1;
        bus.s_awvalid = 0;
        chk("mid_awready", 32'(bus.s_awready), 0);
        chk("pre_rst_cmd_valid", 32'(cmd_valid), 1);
        #2 reset = 1;
        #1;
        chk("arst_cmd_valid", 32'(cmd_valid), 0);
        chk("arst_irq", 32'(irq), 0);
        chk("arst_awready", 32'(bus.s_awready), 1);
        chk("arst_bvalid", 32'(bus.s_bvalid), 0);
        #1 reset = 0;
        model_reset();
        @(posedge clk); #1;
        rd(8'h10, "arst_instr0", 0, 0, obs);
        rd(8'h04, "arst_status", 0, 0, obs);
        rd(8'h00, "arst_ctrl", 0, 0, obs);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
